// File: rtl/julia_scan_pkg.sv
// Shared types and constants for the Julia-set pixel scanner.
package julia_scan_pkg;

  localparam int unsigned COORD_W = 32;
  localparam int unsigned RGB_W   = 16;
  localparam int unsigned ADDR_W  = 17;

  localparam logic [RGB_W-1:0] TIMEOUT_COLOR = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_WRITE = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } scan_state_t;

endpackage

// File: rtl/julia_coord_gen.sv
// Raster position tracker: col/row counters, coordinate accumulators and
// linear frame-buffer address, all stepped by one advance strobe.
module julia_coord_gen
  import julia_scan_pkg::*;
#(
  parameter int unsigned H_RES = 320,
  parameter int unsigned V_RES = 240
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_init,
  input  logic                      i_advance,
  input  logic signed [COORD_W-1:0] i_x_min,
  input  logic signed [COORD_W-1:0] i_y_max,
  input  logic signed [COORD_W-1:0] i_step,
  output logic                      o_last_col_c,
  output logic                      o_last_row_c,
  output logic signed [COORD_W-1:0] o_calc_x,
  output logic signed [COORD_W-1:0] o_calc_y,
  output logic [ADDR_W-1:0]         o_wr_addr
);

  localparam int unsigned COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  logic [COL_W-1:0]          r_col;
  logic [ROW_W-1:0]          r_row;
  logic signed [COORD_W-1:0] r_x_min;
  logic signed [COORD_W-1:0] r_step;
  logic signed [COORD_W-1:0] r_x;
  logic signed [COORD_W-1:0] r_y;
  logic [ADDR_W-1:0]         r_addr;

  assign o_last_col_c = (r_col == COL_W'(H_RES - 1));
  assign o_last_row_c = (r_row == ROW_W'(V_RES - 1));
  assign o_calc_x     = r_x;
  assign o_calc_y     = r_y;
  assign o_wr_addr    = r_addr;

  // Pure accumulation; the last pixel of the frame holds position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_x_min <= '0;
      r_step  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_addr  <= '0;
    end else if (i_init) begin
      r_col   <= '0;
      r_row   <= '0;
      r_x_min <= i_x_min;
      r_step  <= i_step;
      r_x     <= i_x_min;
      r_y     <= i_y_max;
      r_addr  <= '0;
    end else if (i_advance) begin
      if (!o_last_col_c) begin
        r_col  <= r_col + COL_W'(1);
        r_x    <= r_x + r_step;
        r_addr <= r_addr + ADDR_W'(1);
      end else if (!o_last_row_c) begin
        r_col  <= '0;
        r_row  <= r_row + ROW_W'(1);
        r_x    <= r_x_min;
        r_y    <= r_y - r_step;
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/julia_pixel_scan.sv
// Frame scan sequencer: walks every pixel, runs the engine, writes the colour.
// Optional per-pixel watchdog enabled by defining JULIA_SCAN_TIMEOUT_EN.
module julia_pixel_scan
  import julia_scan_pkg::*;
#(
  parameter int unsigned H_RES   = 320,
  parameter int unsigned V_RES   = 240,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] x_min,
  input  logic signed [COORD_W-1:0] y_max,
  input  logic signed [COORD_W-1:0] step,
  output logic                      calc_enable,
  output logic signed [COORD_W-1:0] calc_x,
  output logic signed [COORD_W-1:0] calc_y,
  input  logic                      calc_end,
  input  logic [RGB_W-1:0]          calc_color,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [RGB_W-1:0]          wr_data,
  input  logic                      wr_ready,
  output logic                      busy,
  output logic                      frame_done
`ifdef JULIA_SCAN_TIMEOUT_EN
  ,
  output logic                      timeout_seen
`endif
);

  scan_state_t      r_state;
  scan_state_t      w_next;
  logic             r_load_cnt;
  logic             r_calc_enable;
  logic             r_wr_en;
  logic             r_busy;
  logic             r_frame_done;
  logic [RGB_W-1:0] r_wr_data;
  logic             w_init;
  logic             w_advance;
  logic             w_timeout;
  logic             w_last_col_c;
  logic             w_last_row_c;

  assign w_init    = (r_state == ST_IDLE) && start;
  assign w_advance = (r_state == ST_NEXT);

  julia_coord_gen #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_coord (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_init       (w_init),
    .i_advance    (w_advance),
    .i_x_min      (x_min),
    .i_y_max      (y_max),
    .i_step       (step),
    .o_last_col_c (w_last_col_c),
    .o_last_row_c (w_last_row_c),
    .o_calc_x     (calc_x),
    .o_calc_y     (calc_y),
    .o_wr_addr    (wr_addr)
  );

`ifdef JULIA_SCAN_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_seen;

  assign w_timeout    = (r_state == ST_RUN) && !calc_end && (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign timeout_seen = r_timeout_seen;

  // RUN-cycle watchdog; sticky flag cleared only by reset or an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt       <= '0;
      r_timeout_seen <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == ST_RUN) ? r_to_cnt + TO_W'(1) : '0;
      if (w_init)
        r_timeout_seen <= 1'b0;
      else if (w_timeout)
        r_timeout_seen <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_LOAD;
      ST_LOAD:  if (r_load_cnt) w_next = ST_RUN;
      ST_RUN:   if (calc_end || w_timeout) w_next = ST_WRITE;
      ST_WRITE: if (wr_ready) w_next = ST_NEXT;
      ST_NEXT:  w_next = (w_last_col_c && w_last_row_c) ? ST_DONE : ST_LOAD;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_cnt    <= 1'b0;
      r_calc_enable <= 1'b0;
      r_wr_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_wr_data     <= '0;
    end else begin
      r_load_cnt    <= (r_state == ST_LOAD) ? ~r_load_cnt : 1'b0;
      r_calc_enable <= (w_next == ST_RUN);
      r_wr_en       <= (w_next == ST_WRITE);
      r_busy        <= (w_next == ST_LOAD) || (w_next == ST_RUN) ||
                       (w_next == ST_WRITE) || (w_next == ST_NEXT);
      r_frame_done  <= (w_next == ST_DONE);
      if (r_state == ST_RUN) begin
        if (calc_end)       r_wr_data <= calc_color;
        else if (w_timeout) r_wr_data <= TIMEOUT_COLOR;
      end
    end
  end

  assign calc_enable = r_calc_enable;
  assign wr_en       = r_wr_en;
  assign wr_data     = r_wr_data;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_julia_pixel_scan.sv
// Self-checking bench for julia_pixel_scan on a 4x2 frame with a stub engine.
module tb_julia_pixel_scan;
  localparam int unsigned H  = 4;
  localparam int unsigned V  = 2;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x_min = '0, y_max = '0, step = '0;
  logic        calc_enable;
  logic [31:0] calc_x, calc_y;
  logic        calc_end = 1'b0;
  logic [15:0] calc_color = '0;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready = 1'b1;
  logic        busy, frame_done;
`ifdef JULIA_SCAN_TIMEOUT_EN
  logic        timeout_seen;
`endif

  julia_pixel_scan #(.H_RES(H), .V_RES(V), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_min(x_min), .y_max(y_max), .step(step),
    .calc_enable(calc_enable), .calc_x(calc_x), .calc_y(calc_y),
    .calc_end(calc_end), .calc_color(calc_color),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .frame_done(frame_done)
`ifdef JULIA_SCAN_TIMEOUT_EN
    , .timeout_seen(timeout_seen)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] xm, ym, st;
    int          stall_pix, stall_len;
    bit          hold;
    int          exp_writes, exp_last_addr, exp_done;
  } vec_t;

  typedef struct {
    int          addr;
    logic [15:0] data;
    logic [31:0] x, y;
  } wr_exp_t;

  wr_exp_t     sb[$];
  int          errors = 0, checks = 0;
  int          stall_pix = -1, stall_len = 0, stall_seen = 0;
  bit          stall_unstable = 0;
  logic [15:0] stall_data = '0;
  bit          hold_end = 0;
  int          hang_addr = -1, hang_cycles = 0;
  int          eng_cnt = 0;
  int          wr_cnt = 0, last_addr = -1, done_cnt = 0;
  bit          prev_wr = 0, gap_meas = 0;
  int          gap = 0, gap_err = 0;

  function automatic logic [15:0] color_of(input logic [31:0] x, input logic [31:0] y);
    return {x[19:12], y[19:12]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stub pixel engine: result valid on the 3rd enabled cycle; optional sticky calc_end.
  always @(negedge clk) begin
    if (calc_enable) begin
      eng_cnt++;
      if (int'(wr_addr) == hang_addr) hang_cycles++;
      if (eng_cnt >= 3 && int'(wr_addr) != hang_addr) begin
        if (!calc_end) calc_color = color_of(calc_x, calc_y);
        calc_end = 1'b1;
      end else begin
        calc_end = 1'b0;
      end
    end else begin
      eng_cnt = 0;
      if (!hold_end) calc_end = 1'b0;
    end
  end

  // Frame-buffer model and write scoreboard.
  always @(negedge clk) begin
    wr_exp_t e;
    wr_ready = !(wr_en && int'(wr_addr) == stall_pix && stall_seen < stall_len);
    if (wr_en && int'(wr_addr) == stall_pix) begin
      if (stall_seen == 0) stall_data = wr_data;
      else if (wr_data != stall_data) stall_unstable = 1;
      stall_seen++;
    end
    if (wr_en && wr_ready) begin
      wr_cnt++;
      last_addr = int'(wr_addr);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_write: got addr %0d data %h expected no write", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        chk("calc_x", calc_x, e.x);
        chk("calc_y", calc_y, e.y);
      end
    end
    if (frame_done) done_cnt++;
    if (!rst_n || frame_done) gap_meas = 0;
    else begin
      if (prev_wr && !wr_en) begin gap_meas = 1; gap = 0; end
      if (gap_meas) begin
        if (calc_enable) begin
          if (gap != 3) gap_err++;
          gap_meas = 0;
        end else gap++;
      end
    end
    prev_wr = wr_en;
  end

  task automatic push_model(input vec_t v);
    wr_exp_t e;
    for (int r = 0; r < int'(V); r++)
      for (int c = 0; c < int'(H); c++) begin
        e.addr = r * int'(H) + c;
        e.x    = v.xm + v.st * 32'(c);
        e.y    = v.ym - v.st * 32'(r);
        e.data = (e.addr == hang_addr) ? 16'h0000 : color_of(e.x, e.y);
        sb.push_back(e);
      end
  endtask

  task automatic start_frame(input vec_t v);
    @(negedge clk);
    chk("busy_before_start", 32'(busy), 32'd0);
    x_min = v.xm; y_max = v.ym; step = v.st; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic run_frame(input vec_t v, input bit poke);
    int d0;
    bit seen;
    hold_end = v.hold; stall_pix = v.stall_pix; stall_len = v.stall_len;
    stall_seen = 0; stall_unstable = 0; wr_cnt = 0; last_addr = -1; gap_err = 0;
    d0 = done_cnt;
    push_model(v);
    start_frame(v);
    if (poke) begin
      repeat (15) @(negedge clk);
      x_min = 32'h1234_0000; y_max = 32'h0BAD_0000; step = 32'h0000_1000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1;
        if (poke) start = 1'b1;
      end
    end
    chk("frame_done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("frame_done_count", 32'(done_cnt - d0), 32'(v.exp_done));
    chk("writes_per_frame", 32'(wr_cnt), 32'(v.exp_writes));
    chk("last_addr", 32'(last_addr), 32'(v.exp_last_addr));
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("load_gap_errors", 32'(gap_err), 32'd0);
    if (v.stall_len > 0) begin
      chk("stall_wr_en_cycles", 32'(stall_seen), 32'(v.stall_len + 1));
      chk("stall_data_unstable", 32'(stall_unstable), 32'd0);
    end
    sb.delete();
    hold_end = 0; stall_pix = -1; stall_len = 0;
  endtask

  vec_t vecs[5];

  initial begin
    vec_t rv;
    bit   hit;
    int   d0;
    vecs[0] = '{32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000, -1, 0,  0, 8, 7, 1};
    vecs[1] = '{32'hFFFE_0000, 32'h0001_0000, 32'h0000_8000,  3, 10, 0, 8, 7, 1};
    vecs[2] = '{32'h7FFF_0000, 32'h8001_0000, 32'h0002_0000, -1, 0,  0, 8, 7, 1};
    vecs[3] = '{32'h0000_4000, 32'hFFFF_C000, 32'h0000_4000, -1, 0,  1, 8, 7, 1};
    vecs[4] = '{32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_C000,  6, 2,  0, 8, 7, 1};

    repeat (2) @(negedge clk);
    chk("rst_calc_enable", 32'(calc_enable), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_calc_x", calc_x, 32'd0);
    chk("rst_calc_y", calc_y, 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_frame(vecs[i], 1'b0);

    // start pulses mid-frame and in the DONE cycle must be ignored
    run_frame(vecs[0], 1'b1);

    // asynchronous reset while pixel 5 is in RUN
    rv = vecs[2];
    d0 = done_cnt;
    push_model(rv);
    start_frame(rv);
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (calc_enable && wr_addr == 17'd5) hit = 1;
    end
    chk("reached_pixel5_run", 32'(hit), 32'd1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_calc_enable", 32'(calc_enable), 32'd0);
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_calc_x", calc_x, 32'd0);
    chk("midrst_calc_y", calc_y, 32'd0);
    chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("midrst_wr_data", 32'(wr_data), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
    run_frame(vecs[0], 1'b0);

`ifdef JULIA_SCAN_TIMEOUT_EN
    hang_addr = 2; hang_cycles = 0;
    run_frame(vecs[0], 1'b0);
    chk("timeout_seen", 32'(timeout_seen), 32'd1);
    chk("timeout_run_cycles", 32'(hang_cycles), 32'(TO));
    hang_addr = -1;
    start_frame(vecs[0]);
    chk("timeout_seen_cleared", 32'(timeout_seen), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
